// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Shares one register-file write port between the write-back stage
//            and a small FIFO of long-latency unit results.
// Revision : 1.0
// ============================================================================
module writeback_arbiter #(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pipe_valid,
    input  logic [4:0]                   pipe_rd,
    input  logic [31:0]                  pipe_data,
    output logic                         pipe_stall,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [4:0]                   lu_rd,
    input  logic [31:0]                  lu_data,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int c_AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CW = $clog2(BUF_DEPTH) + 1;
    localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [1:0] c_GRANT_NONE = 2'd0;
    localparam logic [1:0] c_GRANT_PIPE = 2'd1;
    localparam logic [1:0] c_GRANT_BUF  = 2'd2;

    logic [4:0]      r_mem_rd   [BUF_DEPTH];
    logic [31:0]     r_mem_data [BUF_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_SW-1:0] r_starve_cnt;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [31:0]     r_rf_wdata;

    logic       w_empty;
    logic       w_full;
    logic       w_lu_ready;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_grant;

    function automatic logic [c_AW-1:0] next_ptr(input logic [c_AW-1:0] ptr);
        return (ptr == c_AW'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CW'(BUF_DEPTH));
    // Ready depends only on registered occupancy, never on lu_valid or pop.
    assign w_lu_ready = !reset && !w_full;
    assign w_push     = lu_valid && w_lu_ready && (lu_rd != 5'd0);
    assign w_pop      = (w_grant == c_GRANT_BUF);

    always_comb begin
        w_grant = c_GRANT_NONE;
        if (!w_empty && (!pipe_valid || (r_starve_cnt == c_SW'(STARVE_LIMIT)) || w_full)) begin
            w_grant = c_GRANT_BUF;
        end else if (pipe_valid) begin
            w_grant = c_GRANT_PIPE;
        end
    end

    assign lu_ready   = w_lu_ready;
    assign pipe_stall = pipe_valid && (reset || (w_grant != c_GRANT_PIPE));
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign buf_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= lu_rd;
            r_mem_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty) begin
                r_starve_cnt <= '0;
            end else if ((w_grant == c_GRANT_PIPE) && (r_starve_cnt != c_SW'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            case (w_grant)
                c_GRANT_BUF: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_mem_rd[r_rd_ptr];
                    r_rf_wdata <= r_mem_data[r_rd_ptr];
                end
                c_GRANT_PIPE: begin
                    r_rf_we    <= (pipe_rd != 5'd0);
                    r_rf_waddr <= pipe_rd;
                    r_rf_wdata <= pipe_data;
                end
                default: r_rf_we <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed scoreboard bench for writeback_arbiter.
// Revision : 1.0
// ============================================================================
module tb_writeback_arbiter;

    localparam int BUF_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int CW           = $clog2(BUF_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipe_valid = 1'b0;
    logic [4:0]    pipe_rd = '0;
    logic [31:0]   pipe_data = '0;
    logic          pipe_stall;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [4:0]    lu_rd = '0;
    logic [31:0]   lu_data = '0;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [CW-1:0] buf_count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    writeback_arbiter #(.BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
    endtask

    task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en && rf_we !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wb_unexpected: got rf_we=%b rd=%0d data=0x%0h expected no write",
                         rf_we, rf_waddr, rf_wdata);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin
                    n_errors++;
                    $display("FAIL wb_write: got we=%b rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             rf_we, rf_waddr, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        // Reset behaviour, with both sources requesting
        next_cycle();
        mon_en = 1'b1;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        chk("reset_pipe_stall", 32'(pipe_stall), 32'd1);
        chk("reset_lu_ready", 32'(lu_ready), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_buf_count", 32'(buf_count), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("reset_no_push", 32'(buf_count), 32'd0);
        next_cycle();

        // Simple pipeline write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        exp_push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("pipe_stall_empty", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("pipe_rf_we", 32'(rf_we), 32'd1);
        next_cycle();

        // Long-latency result with idle pipe; no same-cycle bypass
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        exp_push(5'd7, 32'h1234);
        @(negedge clk);
        chk("lu_ready_empty", 32'(lu_ready), 32'd1);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("lu_count_1", 32'(buf_count), 32'd1);
        chk("lu_no_bypass", 32'(rf_we), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lu_count_0", 32'(buf_count), 32'd0);
        next_cycle();

        // Starvation limit: four pipe grants then one buffer grant
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h99);
        exp_push(5'd1, 32'h101);
        @(negedge clk);
        chk("starve_first_stall", 32'(pipe_stall), 32'd0);
        next_cycle();
        for (int i = 2; i <= 5; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
            exp_push(5'(i), 32'h100 + 32'(i));
            @(negedge clk);
            chk($sformatf("starve_pipe_grant_%0d", i), 32'(pipe_stall), 32'd0);
            next_cycle();
        end
        drive(1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'd0);
        exp_push(5'd9, 32'h99);
        @(negedge clk);
        chk("starve_buf_grant_stall", 32'(pipe_stall), 32'd1);
        next_cycle();
        exp_push(5'd6, 32'h106);
        @(negedge clk);
        chk("starve_resume_stall", 32'(pipe_stall), 32'd0);
        chk("starve_buf_drained", 32'(buf_count), 32'd0);
        next_cycle();

        // Back-to-back long-latency results while the pipe is busy, pointer wrap
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd10, 32'hA0);
        exp_push(5'd20, 32'h200);
        next_cycle();
        drive(1'b1, 5'd21, 32'h201, 1'b1, 5'd11, 32'hA1);
        exp_push(5'd21, 32'h201);
        next_cycle();
        drive(1'b1, 5'd22, 32'h202, 1'b1, 5'd12, 32'hA2);
        exp_push(5'd10, 32'hA0);
        @(negedge clk);
        chk("full_lu_ready", 32'(lu_ready), 32'd0);
        chk("full_buf_count", 32'(buf_count), 32'd2);
        chk("full_forces_buf", 32'(pipe_stall), 32'd1);
        next_cycle();
        exp_push(5'd22, 32'h202);
        @(negedge clk);
        chk("full_retry_ready", 32'(lu_ready), 32'd1);
        chk("full_pipe_grant", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b1, 5'd23, 32'h203, 1'b0, 5'd0, 32'd0);
        exp_push(5'd11, 32'hA1);
        @(negedge clk);
        chk("refull_forces_buf", 32'(pipe_stall), 32'd1);
        next_cycle();
        exp_push(5'd23, 32'h203);
        @(negedge clk);
        chk("refull_pipe_grant", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_push(5'd12, 32'hA2);
        next_cycle();
        next_cycle();

        // Register zero from both sources
        drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h55);
        @(negedge clk);
        chk("rd0_pipe_stall", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("rd0_buf_count", 32'(buf_count), 32'd0);
        chk("rd0_rf_we", 32'(rf_we), 32'd0);
        next_cycle();

        // Reset with a full buffer discards its contents
        drive(1'b1, 5'd30, 32'h300, 1'b1, 5'd13, 32'hB3);
        exp_push(5'd30, 32'h300);
        next_cycle();
        drive(1'b1, 5'd31, 32'h301, 1'b1, 5'd14, 32'hB4);
        exp_push(5'd31, 32'h301);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_count_before", 32'(buf_count), 32'd2);
        chk("midreset_lu_ready", 32'(lu_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_count_after", 32'(buf_count), 32'd0);
        chk("midreset_rf_we", 32'(rf_we), 32'd0);
        for (int i = 0; i < 4; i++) next_cycle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
